// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the two mux sources and the select arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface mux_select_arbiter_if #(
  parameter int unsigned CW = 4
);
  logic          req1;
  logic          req2;
  logic          s;
  logic          gnt1;
  logic          gnt2;
  logic          busy;
  logic [CW-1:0] remaining;

  modport master (
    output req1,
    output req2,
    input  s,
    input  gnt1,
    input  gnt2,
    input  busy,
    input  remaining
  );

  modport slave (
    input  req1,
    input  req2,
    output s,
    output gnt1,
    output gnt2,
    output busy,
    output remaining
  );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin burst arbiter driving the select input of a 2:1 mux.
// s=1 selects in1 (source 1), s=0 selects in2 (source 2); s only moves when a grant starts.
module mux_select_arbiter #(
  parameter int unsigned BURST = 4,
  parameter int unsigned CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_select_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2
  } state_t;

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_t;

  localparam logic [CW-1:0] RELOAD = CW'(BURST - 1);

  state_t        r_state;
  src_t          r_last;
  logic          r_s;
  logic          r_gnt1;
  logic          r_gnt2;
  logic [CW-1:0] r_rem;

  state_t        w_next;
  src_t          w_last_next;
  logic          w_s_next;
  logic [CW-1:0] w_rem_next;
  logic          w_enter1;
  logic          w_enter2;
  logic          w_end;

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    w_s_next    = r_s;
    w_rem_next  = '0;
    w_enter1    = 1'b0;
    w_enter2    = 1'b0;
    w_end       = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.req1 && bus.req2) begin
          if (r_last == SRC2) w_enter1 = 1'b1;
          else                w_enter2 = 1'b1;
        end else if (bus.req1) begin
          w_enter1 = 1'b1;
        end else if (bus.req2) begin
          w_enter2 = 1'b1;
        end
      end

      G1: begin
        // Burst expiry and early release collapse into a single end-of-grant.
        w_end = (r_rem == '0) || !bus.req1;
        if (w_end) begin
          if (bus.req2)      w_enter2 = 1'b1;
          else if (bus.req1) w_enter1 = 1'b1;
          else               w_next   = IDLE;
        end else begin
          w_rem_next = r_rem - 1'b1;
        end
      end

      G2: begin
        w_end = (r_rem == '0) || !bus.req2;
        if (w_end) begin
          if (bus.req1)      w_enter1 = 1'b1;
          else if (bus.req2) w_enter2 = 1'b1;
          else               w_next   = IDLE;
        end else begin
          w_rem_next = r_rem - 1'b1;
        end
      end

      default: w_next = IDLE;
    endcase

    if (w_enter1) begin
      w_next      = G1;
      w_rem_next  = RELOAD;
      w_last_next = SRC1;
      w_s_next    = 1'b1;
    end else if (w_enter2) begin
      w_next      = G2;
      w_rem_next  = RELOAD;
      w_last_next = SRC2;
      w_s_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= SRC2;
      r_s     <= 1'b0;
      r_gnt1  <= 1'b0;
      r_gnt2  <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
      r_s     <= w_s_next;
      r_gnt1  <= (w_next == G1);
      r_gnt2  <= (w_next == G2);
      r_rem   <= w_rem_next;
    end
  end

  assign bus.s         = r_s;
  assign bus.gnt1      = r_gnt1;
  assign bus.gnt2      = r_gnt2;
  assign bus.busy      = r_gnt1 | r_gnt2;
  assign bus.remaining = r_rem;

endmodule
